// File: rtl/vga_timing_gen_pkg.sv
// Shared 640x480@60 timing constants and sync-bundle types.
// The downstream pointer/ROM-address stage imports this too.
package vga_timing_pkg;

    localparam int COORD_W = 10;

    localparam int VGA_H_VISIBLE = 640;
    localparam int VGA_H_FRONT   = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BACK    = 48;
    localparam int VGA_H_TOTAL   = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;

    localparam int VGA_V_VISIBLE = 480;
    localparam int VGA_V_FRONT   = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BACK    = 33;
    localparam int VGA_V_TOTAL   = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

    localparam int PIX_DIV_DEFAULT    = 4;
    // Registered ROM address (1 CLK) plus synchronous ROM read (1 CLK).
    localparam int SYNC_DELAY_DEFAULT = 2;

    localparam logic SYNC_ACTIVE = 1'b0;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic video_on;
    } sync_bits_t;

    localparam sync_bits_t SYNC_IDLE = '{hsync: ~SYNC_ACTIVE, vsync: ~SYNC_ACTIVE, video_on: 1'b0};

    function automatic logic in_range(coord_t v, coord_t lo, coord_t hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster outputs of the timing generator as seen by the pointer/ROM stage.
interface vga_timing_gen_if;
    import vga_timing_pkg::*;

    coord_t PosX;
    coord_t PosY;
    logic   PixTick;
    logic   FrameStart;
    logic   VideoOn;
    logic   HSync;
    logic   VSync;

    modport master (output PosX, PosY, PixTick, FrameStart, VideoOn, HSync, VSync);
    modport slave  (input  PosX, PosY, PixTick, FrameStart, VideoOn, HSync, VSync);

endinterface

// File: rtl/vga_timing_gen_sync_delay_line.sv
// Fixed-depth shift register with asynchronous active-low reset to a
// programmable idle value; shifts on every clock.
module sync_delay_line #(
    parameter int               WIDTH     = 3,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic [WIDTH-1:0] q_reg;
            if (gi == 0) begin : g_head
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) q_reg <= RESET_VAL;
                    else        q_reg <= din;
                end
            end else begin : g_tail
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) q_reg <= RESET_VAL;
                    else        q_reg <= g_stage[gi-1].q_reg;
                end
            end
        end
    endgenerate

    assign dout = g_stage[DEPTH-1].q_reg;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster generator: pixel-tick divider, H/V position counters and
// delayed HSync/VSync/VideoOn aligned to the downstream ROM read.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int PIX_DIV    = PIX_DIV_DEFAULT,
    parameter int H_VISIBLE  = VGA_H_VISIBLE,
    parameter int H_FRONT    = VGA_H_FRONT,
    parameter int H_SYNC     = VGA_H_SYNC,
    parameter int H_BACK     = VGA_H_BACK,
    parameter int V_VISIBLE  = VGA_V_VISIBLE,
    parameter int V_FRONT    = VGA_V_FRONT,
    parameter int V_SYNC     = VGA_V_SYNC,
    parameter int V_BACK     = VGA_V_BACK,
    parameter int SYNC_DELAY = SYNC_DELAY_DEFAULT
) (
    input  logic              CLK,
    input  logic              RESET,
    vga_timing_gen_if.master  vga
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
    localparam coord_t H_VIS_C  = coord_t'(H_VISIBLE);
    localparam coord_t V_VIS_C  = coord_t'(V_VISIBLE);
    localparam coord_t HS_FIRST = coord_t'(H_VISIBLE + H_FRONT);
    localparam coord_t HS_LAST  = coord_t'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam coord_t VS_FIRST = coord_t'(V_VISIBLE + V_FRONT);
    localparam coord_t VS_LAST  = coord_t'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    localparam int               DIV_W    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

    logic [DIV_W-1:0] div_reg, div_next;
    logic             pix_tick_reg;
    logic             frame_start_reg;
    logic             started_reg;
    logic             frame_wrap;
    coord_t           pos_x_reg, pos_x_next;
    coord_t           pos_y_reg, pos_y_next;
    sync_bits_t       raw_bits;
    sync_bits_t       dly_bits;

    always_comb begin
        div_next   = (div_reg == DIV_LAST) ? '0 : div_reg + 1'b1;
        pos_x_next = pos_x_reg;
        pos_y_next = pos_y_reg;
        frame_wrap = 1'b0;
        if (pix_tick_reg) begin
            if (pos_x_reg == H_LAST) begin
                pos_x_next = '0;
                pos_y_next = (pos_y_reg == V_LAST) ? '0 : pos_y_reg + 1'b1;
                frame_wrap = (pos_y_reg == V_LAST);
            end else begin
                pos_x_next = pos_x_reg + 1'b1;
            end
        end
    end

    // started_reg makes FrameStart fire once right after reset release.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            div_reg         <= '0;
            pix_tick_reg    <= 1'b0;
            frame_start_reg <= 1'b0;
            started_reg     <= 1'b0;
            pos_x_reg       <= '0;
            pos_y_reg       <= '0;
        end else begin
            div_reg         <= div_next;
            pix_tick_reg    <= (div_reg == DIV_LAST);
            frame_start_reg <= frame_wrap || !started_reg;
            started_reg     <= 1'b1;
            pos_x_reg       <= pos_x_next;
            pos_y_reg       <= pos_y_next;
        end
    end

    always_comb begin
        raw_bits = SYNC_IDLE;
        if (in_range(pos_x_reg, HS_FIRST, HS_LAST)) raw_bits.hsync = SYNC_ACTIVE;
        if (in_range(pos_y_reg, VS_FIRST, VS_LAST)) raw_bits.vsync = SYNC_ACTIVE;
        raw_bits.video_on = (pos_x_reg < H_VIS_C) && (pos_y_reg < V_VIS_C);
    end

    sync_delay_line #(
        .WIDTH     ($bits(sync_bits_t)),
        .DEPTH     (SYNC_DELAY),
        .RESET_VAL (SYNC_IDLE)
    ) u_sync_delay (
        .clk   (CLK),
        .rst_n (RESET),
        .din   (raw_bits),
        .dout  (dly_bits)
    );

    assign vga.PosX       = pos_x_reg;
    assign vga.PosY       = pos_y_reg;
    assign vga.PixTick    = pix_tick_reg;
    assign vga.FrameStart = frame_start_reg;
    assign vga.HSync      = dly_bits.hsync;
    assign vga.VSync      = dly_bits.vsync;
    assign vga.VideoOn    = dly_bits.video_on;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a shrunken raster (25x13 pixels,
// 4 CLK per pixel) so several frames and a mid-frame reset fit in a short run.
module tb_vga_timing_gen;
    import vga_timing_pkg::*;

    localparam int PD = 4;
    localparam int HV = 16, HF = 2, HS = 4, HB = 3;
    localparam int VV = 6,  VF = 2, VS = 2, VB = 3;
    localparam int SD = 2;
    localparam int HT = HV + HF + HS + HB;   // 25
    localparam int VT = VV + VF + VS + VB;   // 13
    localparam int FRAME = HT * VT * PD;     // 1300

    logic CLK   = 1'b0;
    logic RESET = 1'b0;
    always #5 CLK = ~CLK;

    vga_timing_gen_if vif();

    vga_timing_gen #(
        .PIX_DIV(PD), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_DELAY(SD)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .vga   (vif)
    );

    typedef struct {
        int n;
        bit rst;
        int x;
        int y;
        bit pix;
        bit fs;
        bit hs;
        bit vs;
        bit von;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    task automatic check(input string name, input int got, input int want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // Closed-form expectation for CLK n after reset release (n = 1 is the first edge).
    function automatic exp_t model(input int n);
        exp_t e;
        int p, m, q, x, y;
        e.n   = n;
        e.rst = 1'b0;
        p     = (n <= 0) ? 0 : (n - 1) / PD;
        e.x   = p % HT;
        e.y   = (p / HT) % VT;
        e.pix = (n > 0) && (n % PD == 0);
        e.fs  = ((n - 1) % FRAME) == 0;
        m     = n - SD;
        if (m < 0) begin
            e.hs = 1'b1; e.vs = 1'b1; e.von = 1'b0;
        end else begin
            q    = (m <= 0) ? 0 : (m - 1) / PD;
            x    = q % HT;
            y    = (q / HT) % VT;
            e.hs  = !(x >= HV + HF && x < HV + HF + HS);
            e.vs  = !(y >= VV + VF && y < VV + VF + VS);
            e.von = (x < HV) && (y < VV);
        end
        return e;
    endfunction

    function automatic exp_t reset_rec();
        exp_t e;
        e = '{n: 0, rst: 1'b1, x: 0, y: 0, pix: 1'b0, fs: 1'b0, hs: 1'b1, vs: 1'b1, von: 1'b0};
        return e;
    endfunction

    // Expectation producer: one record per clock edge.
    always @(posedge CLK) begin
        if (!RESET) begin
            cyc = 0;
            exp_q.push_back(reset_rec());
        end else begin
            cyc = cyc + 1;
            exp_q.push_back(model(cyc));
        end
    end

    exp_t e;
    int   hs_low_start = -1, vs_low_start = -1, last_fs = -1, x18_cyc = -1;
    int   prev_x = 0;
    bit   prev_hs = 1'b1, prev_vs = 1'b1;
    bit   first_pix_seen = 1'b0, first_x1_seen = 1'b0, first_vs_seen = 1'b0;
    int   hs_runs = 0, vs_runs = 0, fs_periods = 0;

    // Monitor: pops one expectation per edge and compares, plus event-level timing checks.
    always @(posedge CLK) begin
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (vif.PosX !== 10'(e.x) || vif.PosY !== 10'(e.y) || vif.PixTick !== e.pix ||
                vif.FrameStart !== e.fs || vif.HSync !== e.hs || vif.VSync !== e.vs ||
                vif.VideoOn !== e.von) begin
                n_fail++;
                $display("FAIL cycle n=%0d rst=%0b: got x=%0d y=%0d tick=%b fs=%b hs=%b vs=%b von=%b, want x=%0d y=%0d tick=%b fs=%b hs=%b vs=%b von=%b",
                         e.n, e.rst, vif.PosX, vif.PosY, vif.PixTick, vif.FrameStart, vif.HSync,
                         vif.VSync, vif.VideoOn, e.x, e.y, e.pix, e.fs, e.hs, e.vs, e.von);
            end
            if (e.rst) begin
                hs_low_start = -1; vs_low_start = -1; last_fs = -1; x18_cyc = -1;
                prev_x = 0; prev_hs = 1'b1; prev_vs = 1'b1;
                first_pix_seen = 1'b0; first_x1_seen = 1'b0; first_vs_seen = 1'b0;
            end else begin
                if (vif.PixTick && !first_pix_seen) begin
                    first_pix_seen = 1'b1;
                    check("first_pixtick_cycle", e.n, 4);
                end
                if (vif.PosX == 10'd1 && !first_x1_seen) begin
                    first_x1_seen = 1'b1;
                    check("first_posx1_cycle", e.n, 5);
                end
                if (vif.FrameStart) begin
                    if (last_fs < 0) check("first_framestart_cycle", e.n, 1);
                    else begin
                        check("framestart_period", e.n - last_fs, 1300);
                        fs_periods++;
                    end
                    last_fs = e.n;
                end
                if (vif.PosX == 10'd18 && prev_x != 18) x18_cyc = e.n;
                if (!vif.HSync && prev_hs) begin
                    hs_low_start = e.n;
                    if (x18_cyc >= 0) check("hsync_fall_lag", e.n - x18_cyc, 2);
                end
                if (vif.HSync && !prev_hs && hs_low_start >= 0) begin
                    check("hsync_low_len", e.n - hs_low_start, 16);
                    hs_runs++;
                end
                if (!vif.VSync && prev_vs) begin
                    if (!first_vs_seen) begin
                        first_vs_seen = 1'b1;
                        check("first_vsync_fall_cycle", e.n, 803);
                    end
                    vs_low_start = e.n;
                end
                if (vif.VSync && !prev_vs && vs_low_start >= 0) begin
                    check("vsync_low_len", e.n - vs_low_start, 200);
                    vs_runs++;
                end
                prev_x  = int'(vif.PosX);
                prev_hs = vif.HSync;
                prev_vs = vif.VSync;
            end
        end
    end

    initial begin
        RESET = 1'b0;
        repeat (10) @(negedge CLK);
        $display("reset held 10 CLK, releasing");
        RESET = 1'b1;

        for (int i = 0; i < 5000 && cyc < 3582; i++) @(negedge CLK);
        check("reset_target_reached", cyc, 3582);
        check("pre_reset_posx", int'(vif.PosX), 20);
        check("pre_reset_posy", int'(vif.PosY), 9);
        check("pre_reset_vsync_low", int'(vif.VSync), 0);
        $display("two frames run, pulsing reset at (20, 9) with VSync low");

        RESET = 1'b0;
        #1;
        check("async_rst_vsync", int'(vif.VSync), 1);
        check("async_rst_hsync", int'(vif.HSync), 1);
        check("async_rst_posx", int'(vif.PosX), 0);
        check("async_rst_posy", int'(vif.PosY), 0);
        check("async_rst_videoon", int'(vif.VideoOn), 0);
        repeat (3) @(negedge CLK);
        RESET = 1'b1;
        $display("reset released after 3 CLK, running 1000 CLK");

        repeat (1000) @(negedge CLK);
        check("vsync_seen_after_reset", int'(first_vs_seen), 1);
        check("pixtick_seen_after_reset", int'(first_pix_seen), 1);
        check("framestart_periods_seen", fs_periods, 2);
        check("vsync_runs_seen", vs_runs, 2);
        check("hsync_runs_nonzero", int'(hs_runs > 0), 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
